// File: rtl/uart_tx_fifo_if.sv
// Write-side handshake plus UART line outputs of the buffered transmitter.
// The master drives the write request. The slave is the transmitter itself.
interface uart_tx_fifo_if #(
   parameter int FIFO_DEPTH = 16
);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic             i_Wr_En;
   logic [7:0]       i_Wr_Byte;
   logic             o_Full;
   logic             o_Empty;
   logic [CNT_W-1:0] o_Count;
   logic             o_Overflow;
   logic             o_Tx_Serial;
   logic             o_Tx_Active;
   logic             o_Tx_Done;

   modport master (
      output i_Wr_En, i_Wr_Byte,
      input  o_Full, o_Empty, o_Count, o_Overflow,
      input  o_Tx_Serial, o_Tx_Active, o_Tx_Done
   );

   modport slave (
      input  i_Wr_En, i_Wr_Byte,
      output o_Full, o_Empty, o_Count, o_Overflow,
      output o_Tx_Serial, o_Tx_Active, o_Tx_Done
   );
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter.
// A small FIFO accepts bytes from fabric logic. A four-state FSM pops one byte
// at a time and paces it onto the line with a per-bit baud counter.
module uart_tx_fifo #(
   parameter int CLKS_PER_BIT = 868,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic          CLK,
   input  logic          RST_N,
   uart_tx_fifo_if.slave bus
);
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int BAUD_W = $clog2(CLKS_PER_BIT);
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   // ---------------- FIFO ----------------
   logic [7:0]       mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             overflow_q, overflow_d;
   logic             full, empty, wr_acc, pop;
   logic [7:0]       head;

   // ---------------- transmitter ----------------
   state_t           state_q;
   logic [BAUD_W-1:0] baud_q;
   logic [2:0]       bit_idx_q;
   logic [7:0]       shift_q;
   logic             serial_q, active_q, done_q;

   // Full/empty come from the registered count. A write is judged on the
   // pre-edge count, so a same-cycle pop never makes room for it.
   assign full   = (count_q == CNT_FULL);
   assign empty  = (count_q == '0);
   assign wr_acc = bus.i_Wr_En && !full;
   assign pop    = (state_q == IDLE) && !empty;
   assign head   = mem_q[rd_ptr_q];

   // Next-state for pointers, occupancy and the overflow pulse
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = bus.i_Wr_En && full;
      if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)    rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({wr_acc, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // FIFO control registers
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   // FIFO storage. The contents need no reset because the pointers gate every read.
   always_ff @(posedge CLK) begin
      if (wr_acc) mem_q[wr_ptr_q] <= bus.i_Wr_Byte;
   end

   // Frame FSM with registered line outputs. Each output is set to the value
   // that belongs to the state being entered.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q   <= IDLE;
         baud_q    <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         serial_q  <= 1'b1;
         active_q  <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               serial_q <= 1'b1;
               active_q <= 1'b0;
               baud_q   <= '0;
               if (pop) begin
                  shift_q  <= head;
                  state_q  <= START;
                  serial_q <= 1'b0;
                  active_q <= 1'b1;
               end
            end
            START: begin
               if (baud_q == BAUD_LAST) begin
                  baud_q    <= '0;
                  bit_idx_q <= '0;
                  state_q   <= DATA;
                  serial_q  <= shift_q[0];
               end else begin
                  baud_q <= baud_q + BAUD_W'(1);
               end
            end
            DATA: begin
               if (baud_q == BAUD_LAST) begin
                  baud_q <= '0;
                  if (bit_idx_q == 3'd7) begin
                     state_q  <= STOP;
                     serial_q <= 1'b1;
                  end else begin
                     bit_idx_q <= bit_idx_q + 3'd1;
                     serial_q  <= shift_q[bit_idx_q + 3'd1];
                  end
               end else begin
                  baud_q <= baud_q + BAUD_W'(1);
               end
            end
            STOP: begin
               if (baud_q == BAUD_LAST) begin
                  baud_q   <= '0;
                  state_q  <= IDLE;
                  active_q <= 1'b0;
                  done_q   <= 1'b1;
               end else begin
                  baud_q <= baud_q + BAUD_W'(1);
               end
            end
            default: begin
               state_q  <= IDLE;
               serial_q <= 1'b1;
               active_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.o_Full      = full;
   assign bus.o_Empty     = empty;
   assign bus.o_Count     = count_q;
   assign bus.o_Overflow  = overflow_q;
   assign bus.o_Tx_Serial = serial_q;
   assign bus.o_Tx_Active = active_q;
   assign bus.o_Tx_Done   = done_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo with CLKS_PER_BIT=4 and FIFO_DEPTH=4.
// The stimulus pushes each accepted byte onto exp_q. A line monitor decodes
// frames, pops exp_q and compares the decoded byte.
module tb_uart_tx_fifo;
   localparam int CPB   = 4;
   localparam int DEPTH = 4;

   logic CLK = 1'b0;
   logic RST_N = 1'b1;
   always #5 CLK = ~CLK;

   uart_tx_fifo_if #(.FIFO_DEPTH(DEPTH)) bus_if ();

   uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .bus   (bus_if)
   );

   int         n_tests = 0;
   int         n_fail  = 0;
   int         cyc     = 0;
   int         frames  = 0;
   int         done_cnt = 0;
   int         mon_c   = -1;
   logic [7:0] mon_byte;
   logic [7:0] exp_q [$];
   int         starts [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(posedge CLK) cyc++;
   always @(negedge CLK) if (bus_if.o_Tx_Done) done_cnt++;

   // Line monitor. Sample count 0 is the first falling clock edge after the
   // start bit appears. Each bit is sampled mid-period.
   always @(negedge CLK) begin
      if (!RST_N) begin
         mon_c = -1;
      end else if (mon_c < 0) begin
         if (!bus_if.o_Tx_Serial) begin
            mon_c    = 0;
            mon_byte = 8'h00;
            starts.push_back(cyc);
            chk("start_active", bus_if.o_Tx_Active, 1);
         end
      end else begin
         mon_c++;
      end
      if (RST_N && mon_c >= 0) begin
         if (mon_c == CPB/2)
            chk("start_low", bus_if.o_Tx_Serial, 0);
         if (mon_c >= CPB + CPB/2 && mon_c < 9*CPB && ((mon_c - CPB/2) % CPB) == 0)
            mon_byte[(mon_c - CPB/2)/CPB - 1] = bus_if.o_Tx_Serial;
         if (mon_c == 9*CPB + CPB/2) begin
            chk("stop_high", bus_if.o_Tx_Serial, 1);
            chk("done_early", bus_if.o_Tx_Done, 0);
         end
         if (mon_c == 10*CPB) begin
            chk("done_pulse", bus_if.o_Tx_Done, 1);
            chk("active_end", bus_if.o_Tx_Active, 0);
            if (exp_q.size() == 0) begin
               chk("unexpected_frame", {24'h0, mon_byte}, 32'hFFFF_FFFF);
            end else begin
               chk("frame_byte", mon_byte, exp_q.pop_front());
            end
            frames++;
            mon_c = -1;
         end
      end
   end

   // Present one byte for the next rising edge. On return we are 1 ns past that edge.
   task automatic wr(input logic [7:0] b, input bit accept);
      bus_if.i_Wr_En   = 1'b1;
      bus_if.i_Wr_Byte = b;
      if (accept) exp_q.push_back(b);
      @(posedge CLK);
      #1;
      bus_if.i_Wr_En = 1'b0;
   endtask

   task automatic chk_spacing(input int first, input int n, input string name);
      for (int i = first + 1; i < first + n; i++) begin
         if (i < starts.size()) chk(name, starts[i] - starts[i-1], 10*CPB + 1);
         else chk({name, "_missing"}, i, starts.size());
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int s0, f0, d0;
      bit got;
      bus_if.i_Wr_En   = 1'b0;
      bus_if.i_Wr_Byte = 8'h00;

      // 1. asynchronous reset, checked before any clock edge
      #2 RST_N = 1'b0;
      #1;
      chk("rst_serial",   bus_if.o_Tx_Serial, 1);
      chk("rst_active",   bus_if.o_Tx_Active, 0);
      chk("rst_done",     bus_if.o_Tx_Done, 0);
      chk("rst_overflow", bus_if.o_Overflow, 0);
      chk("rst_full",     bus_if.o_Full, 0);
      chk("rst_empty",    bus_if.o_Empty, 1);
      chk("rst_count",    bus_if.o_Count, 0);
      repeat (2) @(posedge CLK);
      #3 RST_N = 1'b1;
      @(posedge CLK); #1;
      chk("rel_serial", bus_if.o_Tx_Serial, 1);
      chk("rel_count",  bus_if.o_Count, 0);

      // 2. single byte 0xA5, with write-to-line latency
      d0 = done_cnt; f0 = frames;
      wr(8'hA5, 1);
      @(negedge CLK);
      chk("a5_cnt_k",    bus_if.o_Count, 1);
      chk("a5_serial_k", bus_if.o_Tx_Serial, 1);
      chk("a5_active_k", bus_if.o_Tx_Active, 0);
      @(negedge CLK);
      chk("a5_serial_k1", bus_if.o_Tx_Serial, 0);
      chk("a5_active_k1", bus_if.o_Tx_Active, 1);
      chk("a5_empty_k1",  bus_if.o_Empty, 1);
      repeat (45) @(negedge CLK);
      chk("a5_frames", frames - f0, 1);
      chk("a5_dones",  done_cnt - d0, 1);

      // 3. burst, then overflow on a full FIFO
      @(posedge CLK); #1;
      s0 = starts.size(); f0 = frames;
      wr(8'h01, 1);
      wr(8'h02, 1);
      wr(8'h03, 1);
      wr(8'h04, 1);
      wr(8'h05, 1);
      @(negedge CLK);
      chk("burst_count", bus_if.o_Count, 4);
      chk("burst_full",  bus_if.o_Full, 1);
      chk("burst_ovf0",  bus_if.o_Overflow, 0);
      wr(8'hFF, 0);
      @(negedge CLK);
      chk("burst_ovf",   bus_if.o_Overflow, 1);
      chk("burst_cnt_ovf", bus_if.o_Count, 4);
      @(negedge CLK);
      chk("burst_ovf_clr", bus_if.o_Overflow, 0);

      // 4. write on the pop edge while full: rejected, count drops to 3
      got = 0;
      for (int i = 0; i < 60 && !got; i++) begin
         @(negedge CLK);
         if (bus_if.o_Tx_Done) got = 1;
      end
      chk("wait_done_01", got, 1);
      chk("pop_edge_full", bus_if.o_Full, 1);
      bus_if.i_Wr_En   = 1'b1;
      bus_if.i_Wr_Byte = 8'h77;
      @(posedge CLK); #1;
      bus_if.i_Wr_En = 1'b0;
      @(negedge CLK);
      chk("popedge_ovf",   bus_if.o_Overflow, 1);
      chk("popedge_count", bus_if.o_Count, 3);
      chk("popedge_full",  bus_if.o_Full, 0);
      repeat (170) @(negedge CLK);
      chk("burst_frames", frames - f0, 5);
      chk_spacing(s0, 5, "burst_spacing");

      // 5. write during a frame
      @(posedge CLK); #1;
      s0 = starts.size(); f0 = frames;
      wr(8'h10, 1);
      repeat (8) @(posedge CLK);
      #1;
      wr(8'h42, 1);
      @(negedge CLK);
      chk("mid_count",  bus_if.o_Count, 1);
      chk("mid_active", bus_if.o_Tx_Active, 1);
      repeat (90) @(negedge CLK);
      chk("mid_frames", frames - f0, 2);
      chk_spacing(s0, 2, "mid_spacing");

      // 6. reset during DATA bit 3 of 0xC3 with two bytes queued
      @(posedge CLK); #1;
      wr(8'hC3, 1);
      wr(8'h11, 1);
      wr(8'h22, 1);
      repeat (16) @(posedge CLK);
      #3;
      RST_N = 1'b0;
      exp_q.delete();
      #1;
      chk("mrst_serial", bus_if.o_Tx_Serial, 1);
      chk("mrst_count",  bus_if.o_Count, 0);
      chk("mrst_active", bus_if.o_Tx_Active, 0);
      chk("mrst_done",   bus_if.o_Tx_Done, 0);
      repeat (2) @(negedge CLK);
      #2 RST_N = 1'b1;
      s0 = starts.size(); f0 = frames; d0 = done_cnt;
      repeat (60) @(negedge CLK);
      chk("post_rst_starts", starts.size() - s0, 0);
      chk("post_rst_dones",  done_cnt - d0, 0);
      chk("post_rst_line",   bus_if.o_Tx_Serial, 1);
      @(posedge CLK); #1;
      wr(8'h5A, 1);
      @(negedge CLK);
      chk("post_rst_k",  bus_if.o_Tx_Serial, 1);
      @(negedge CLK);
      chk("post_rst_k1", bus_if.o_Tx_Serial, 0);
      repeat (45) @(negedge CLK);
      chk("post_rst_frames", frames - f0, 1);

      chk("queue_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
